// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline interlock, forwarding select, fetch kill and
// mul/div occupancy tracking for a classic 5-stage in-order core.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   id_rs, id_rt              ID source register numbers
//   id_rs_rd, id_rt_rd        ID instruction really reads rs / rt
//   id_branch, id_jump        ID holds a conditional branch / jump
//   id_md_start, id_md_use    ID starts mul/div / reads HI-LO
//   ex_wr, ex_load, ex_rd     EX-stage writeback info
//   mem_wr, mem_rd            MEM-stage writeback info
//   pc_wr, ifid_wr, idex_nop  stall controls (combinational)
//   if_kill                   one-cycle kill of the wrong-path fetch
//   md_busy                   mul/div unit occupied
//   fwd_a, fwd_b              operand select: 00 reg, 01 EX, 10 MEM
//
// Build option: define HAZARD_FORWARD_EN to enable EX/MEM forwarding.
// Without it every RAW dependency on EX or MEM is resolved by stalling.

module hazard_ctrl #(
    parameter int AW     = 5,
    parameter int MD_LAT = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] id_rs,
    input  logic [AW-1:0] id_rt,
    input  logic          id_rs_rd,
    input  logic          id_rt_rd,
    input  logic          id_branch,
    input  logic          id_jump,
    input  logic          id_md_start,
    input  logic          id_md_use,
    input  logic          ex_wr,
    input  logic          ex_load,
    input  logic [AW-1:0] ex_rd,
    input  logic          mem_wr,
    input  logic [AW-1:0] mem_rd,
    output logic          pc_wr,
    output logic          ifid_wr,
    output logic          idex_nop,
    output logic          if_kill,
    output logic          md_busy,
    output logic [1:0]    fwd_a,
    output logic [1:0]    fwd_b
);

    localparam int CW = (MD_LAT > 1) ? $clog2(MD_LAT) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(MD_LAT - 1);

    typedef enum logic {
        IDLE    = 1'b0,
        MD_BUSY = 1'b1
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;

    // Register 0 is hardwired to zero, so it never carries a dependency.
    logic ex_rs, ex_rt, mem_rs, mem_rt;

    assign ex_rs  = id_rs_rd & ex_wr  & (id_rs == ex_rd)  & (ex_rd  != '0);
    assign ex_rt  = id_rt_rd & ex_wr  & (id_rt == ex_rd)  & (ex_rd  != '0);
    assign mem_rs = id_rs_rd & mem_wr & (id_rs == mem_rd) & (mem_rd != '0);
    assign mem_rt = id_rt_rd & mem_wr & (id_rt == mem_rd) & (mem_rd != '0);

    logic load_stall, br_stall, md_stall, fwd_stall, stall;
    logic br_ctrl;

    // Branch compare lives in ID: it can take a MEM bypass but not an
    // ALU result still being computed in EX.
    assign br_ctrl    = id_branch | (id_jump & id_rs_rd);
    assign load_stall = ex_load & (ex_rs | ex_rt);
    assign br_stall   = br_ctrl & ~ex_load & (ex_rs | ex_rt);
    assign md_stall   = md_busy & (id_md_use | id_md_start);

`ifdef HAZARD_FORWARD_EN
    assign fwd_stall = 1'b0;

    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (ex_rs && !ex_load) fwd_a = 2'b01;
        else if (mem_rs)       fwd_a = 2'b10;
        if (ex_rt && !ex_load) fwd_b = 2'b01;
        else if (mem_rt)       fwd_b = 2'b10;
    end
`else
    assign fwd_stall = ex_rs | ex_rt | mem_rs | mem_rt;
    assign fwd_a     = 2'b00;
    assign fwd_b     = 2'b00;
`endif

    assign stall    = load_stall | br_stall | md_stall | fwd_stall;
    assign pc_wr    = ~stall;
    assign ifid_wr  = ~stall;
    assign idex_nop = stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            md_busy <= 1'b0;
            if_kill <= 1'b0;
        end else begin
            // Set only when the transfer leaves ID; self-clears next edge.
            if_kill <= (id_branch | id_jump) & ~stall & ~if_kill;

            case (state)
                IDLE: begin
                    if (id_md_start && !stall) begin
                        state   <= MD_BUSY;
                        cnt     <= CNT_INIT;
                        md_busy <= 1'b1;
                    end
                end
                MD_BUSY: begin
                    if (cnt == '0) begin
                        state   <= IDLE;
                        md_busy <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    md_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench for hazard_ctrl (MD_LAT = 4).
// Expected outputs are queued per driven cycle and compared mid-cycle.

module tb_hazard_ctrl;

`ifdef HAZARD_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs, id_rt, ex_rd, mem_rd;
    logic       id_rs_rd, id_rt_rd, id_branch, id_jump;
    logic       id_md_start, id_md_use;
    logic       ex_wr, ex_load, mem_wr;
    logic       pc_wr, ifid_wr, idex_nop, if_kill, md_busy;
    logic [1:0] fwd_a, fwd_b;

    always #5 clk = ~clk;

    hazard_ctrl #(.AW(5), .MD_LAT(4)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_rd(id_rs_rd), .id_rt_rd(id_rt_rd),
        .id_branch(id_branch), .id_jump(id_jump),
        .id_md_start(id_md_start), .id_md_use(id_md_use),
        .ex_wr(ex_wr), .ex_load(ex_load), .ex_rd(ex_rd),
        .mem_wr(mem_wr), .mem_rd(mem_rd),
        .pc_wr(pc_wr), .ifid_wr(ifid_wr), .idex_nop(idex_nop),
        .if_kill(if_kill), .md_busy(md_busy),
        .fwd_a(fwd_a), .fwd_b(fwd_b)
    );

    typedef struct {
        logic       stall;
        logic       kill;
        logic       busy;
        logic [1:0] fa;
        logic [1:0] fb;
    } exp_t;

    exp_t q[$];
    int   n_run  = 0;
    int   n_fail = 0;
    int   step   = 0;

    task automatic check(input string tag, input logic [7:0] got,
                         input logic [7:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0h expected %0h",
                     tag, step, got, exp);
        end
    endtask

    task automatic clr();
        id_rs = '0; id_rt = '0; ex_rd = '0; mem_rd = '0;
        id_rs_rd = 0; id_rt_rd = 0; id_branch = 0; id_jump = 0;
        id_md_start = 0; id_md_use = 0;
        ex_wr = 0; ex_load = 0; mem_wr = 0;
    endtask

    task automatic push(input logic s, input logic k, input logic b,
                        input logic [1:0] fa, input logic [1:0] fb);
        exp_t e;
        e.stall = s; e.kill = k; e.busy = b; e.fa = fa; e.fb = fb;
        q.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        #2;
        if (q.size() == 0) begin
            check("queue_empty", 8'd0, 8'd1);
        end else begin
            e = q.pop_front();
            check("pc_wr",    {7'd0, pc_wr},    {7'd0, ~e.stall});
            check("ifid_wr",  {7'd0, ifid_wr},  {7'd0, ~e.stall});
            check("idex_nop", {7'd0, idex_nop}, {7'd0, e.stall});
            check("if_kill",  {7'd0, if_kill},  {7'd0, e.kill});
            check("md_busy",  {7'd0, md_busy},  {7'd0, e.busy});
            check("fwd_a",    {6'd0, fwd_a},    {6'd0, e.fa});
            check("fwd_b",    {6'd0, fwd_b},    {6'd0, e.fb});
        end
        step++;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        clr();
        @(negedge clk);

        // reset state
        push(0, 0, 0, 2'b00, 2'b00); tick();
        rst = 1'b0;

        // load-use on rs
        ex_load = 1; ex_wr = 1; ex_rd = 5; id_rs = 5; id_rs_rd = 1;
        push(1, 0, 0, 2'b00, 2'b00); tick();

        // load now in MEM
        clr(); mem_wr = 1; mem_rd = 5; id_rs = 5; id_rs_rd = 1;
        push(!FWD, 0, 0, FWD ? 2'b10 : 2'b00, 2'b00); tick();

        // r0 never matches
        clr(); ex_wr = 1; ex_rd = 0; id_rs = 0; id_rs_rd = 1;
        push(0, 0, 0, 2'b00, 2'b00); tick();

        // EX beats MEM on rt
        clr(); ex_wr = 1; ex_rd = 7; mem_wr = 1; mem_rd = 7;
        id_rt = 7; id_rt_rd = 1;
        push(!FWD, 0, 0, 2'b00, FWD ? 2'b01 : 2'b00); tick();

        // MEM-only on rt
        clr(); mem_wr = 1; mem_rd = 9; id_rt = 9; id_rt_rd = 1;
        push(!FWD, 0, 0, 2'b00, FWD ? 2'b10 : 2'b00); tick();

        // address match but rs not read
        clr(); ex_wr = 1; ex_rd = 5; id_rs = 5;
        push(0, 0, 0, 2'b00, 2'b00); tick();

        // branch held two cycles by ALU producer in EX
        for (int i = 0; i < 2; i++) begin
            clr(); id_branch = 1; id_rs = 3; id_rs_rd = 1;
            ex_wr = 1; ex_rd = 3;
            push(1, 0, 0, FWD ? 2'b01 : 2'b00, 2'b00); tick();
        end
        clr(); id_branch = 1; id_rs = 3; id_rs_rd = 1;
        push(0, 0, 0, 2'b00, 2'b00); tick();
        clr();
        push(0, 1, 0, 2'b00, 2'b00); tick();
        push(0, 0, 0, 2'b00, 2'b00); tick();

        // jump held while kill is up: still one kill
        id_jump = 1;
        push(0, 0, 0, 2'b00, 2'b00); tick();
        push(0, 1, 0, 2'b00, 2'b00); tick();
        clr();
        push(0, 0, 0, 2'b00, 2'b00); tick();

        // mul/div: busy exactly 4 cycles, HI-LO read stalls
        id_md_start = 1;
        push(0, 0, 0, 2'b00, 2'b00); tick();
        for (int i = 0; i < 4; i++) begin
            clr(); id_md_use = 1;
            if (i == 1) begin
                ex_load = 1; ex_wr = 1; ex_rd = 5;
                id_rs = 5; id_rs_rd = 1;
            end
            push(1, 0, 1, 2'b00, 2'b00); tick();
        end
        clr(); id_md_use = 1;
        push(0, 0, 0, 2'b00, 2'b00); tick();

        // back-to-back start waits for idle
        clr(); id_md_start = 1;
        push(0, 0, 0, 2'b00, 2'b00); tick();
        for (int i = 0; i < 4; i++) begin
            push(1, 0, 1, 2'b00, 2'b00); tick();
        end
        push(0, 0, 0, 2'b00, 2'b00); tick();
        clr();
        push(0, 0, 1, 2'b00, 2'b00); tick();

        // reset at count 2, with a jump that must not kill
        rst = 1; id_jump = 1;
        push(0, 0, 1, 2'b00, 2'b00); tick();
        rst = 0; clr();
        push(0, 0, 0, 2'b00, 2'b00); tick();
        push(0, 0, 0, 2'b00, 2'b00); tick();

        check("queue_drained", q.size()[7:0], 8'd0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter AW, default 5, register-address width.
REQ-002 SHALL have parameter MD_LAT, default 32, multiply/divide unit occupancy in cycles (>=2).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports id_rs, id_rt  input  AW each  ID source register numbers.
REQ-006 SHALL have ports id_rs_rd, id_rt_rd  input  1 each  ID instruction actually reads rs / rt.
REQ-007 SHALL have ports id_branch, id_jump  input  1 each  ID holds a conditional branch / j, jal, jr, jalr.
REQ-008 SHALL have ports id_md_start, id_md_use  input  1 each  ID starts mul/div / reads HI-LO.
REQ-009 SHALL have ports ex_wr, ex_load  input  1 each and ex_rd  input  AW  EX-stage writeback info.
REQ-010 SHALL have ports mem_wr  input  1 and mem_rd  input  AW  MEM-stage writeback info.
REQ-011 SHALL have outputs pc_wr, ifid_wr, idex_nop, if_kill, md_busy  1 each and fwd_a, fwd_b  2 each.

Function
REQ-012 Match(x, y) SHALL be true only when x == y, y != 0, and the corresponding read/write enable is 1.
REQ-013 load_stall SHALL be ex_load & ex_wr & (Match(id_rs, ex_rd) | Match(id_rt, ex_rd)).
REQ-014 br_stall SHALL be (id_branch | jr/jalr reading rs) & ex_wr & !ex_load & a source Match on ex_rd; the branch compare sits in ID and takes MEM forwarding only.
REQ-015 md_stall SHALL be md_busy & (id_md_use | id_md_start).
REQ-016 stall = load_stall | br_stall | md_stall | fwd_stall (REQ-028); while stall: pc_wr=0, ifid_wr=0, idex_nop=1, all combinational, same cycle.
REQ-017 fwd_a SHALL be 2'b01 on Match(id_rs, ex_rd) with !ex_load, otherwise 2'b10 on Match(id_rs, mem_rd), otherwise 2'b00; fwd_b is the same for id_rt; EX has priority over MEM.
REQ-018 if_kill SHALL be a register set at a clock edge when ID holds id_branch|id_jump, stall=0 and if_kill=0; it clears on the following edge, giving exactly one killed fetch per control transfer.
REQ-019 A control transfer held by stall SHALL NOT set if_kill until the cycle it is accepted, so the kill is issued once, not once per stalled cycle.
REQ-020 The FSM SHALL have states IDLE and MD_BUSY; md_busy=1 exactly in MD_BUSY.
REQ-021 In IDLE, id_md_start with stall=0 SHALL load the counter with MD_LAT-1 and move to MD_BUSY at the edge.
REQ-022 In MD_BUSY the counter SHALL decrement by 1 per cycle; at count 0 the next edge SHALL enter IDLE, and that edge SHALL NOT decrement below 0 (no wrap).
REQ-023 The counter width SHALL be clog2(MD_LAT).
REQ-024 A new id_md_start is stalled until IDLE; a start in the same cycle as busy release SHALL NOT be accepted until md_busy=0.
REQ-025 When several stall causes are active simultaneously, all stall outputs are identical to a single cause, and the FSM and counter still advance.

Reset
REQ-026 On rst=1 at a clock edge: state=IDLE, counter=0, if_kill=0; rst takes priority over every other event, including mid-MD_BUSY.
REQ-027 With rst=1 and zero stall inputs: pc_wr=1, ifid_wr=1, idex_nop=0, md_busy=0, fwd_a=fwd_b=2'b00.

Configuration
REQ-028 Macro HAZARD_FORWARD_EN: when defined, REQ-017 applies and fwd_stall=0; when undefined, fwd_a=fwd_b=2'b00 always and fwd_stall=1 on any source Match against ex_rd or mem_rd (full interlock, no forwarding).

Verification
REQ-029 ex_load=1, ex_wr=1, ex_rd=5, id_rs=5, id_rs_rd=1 -> pc_wr=0, ifid_wr=0, idex_nop=1 for one cycle; next cycle (ex_load=0) fwd_a=2'b10 after the load advances.
REQ-030 ex_wr=1, ex_rd=0, id_rs=0 -> no stall, fwd_a=2'b00; with ex_rd=mem_rd=7 and id_rt=7 -> fwd_b=2'b01.
REQ-031 id_md_start pulse with MD_LAT=4 -> md_busy high exactly 4 cycles; id_md_use during those cycles -> stall each cycle, release on the cycle md_busy falls.
REQ-032 id_branch=1 held 2 cycles by br_stall (ex_rd=3=id_rs) -> if_kill high exactly one cycle, after stall drops.
REQ-033 rst asserted at count 2 of MD_BUSY -> next cycle md_busy=0, if_kill=0, pc_wr=1.
REQ-034 Without HAZARD_FORWARD_EN: mem_wr=1, mem_rd=9, id_rt=9, id_rt_rd=1 -> stall=1, fwd_b=2'b00.
